// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU built-in self-test.
//   - ALUControl opcodes driven towards Top_ALU
//   - FSM state encoding of the BIST sequencer
//   - index width of the vector table
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Vector table holds 8 entries, so a 3-bit index covers it.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_vec_rom.sv
// alu_vec_rom: fixed stimulus/response table for the ALU self-test.
// Purely combinational lookup.
//   idx        in   table index
//   a, b       out  operands for the ALU
//   ctrl       out  ALUControl opcode
//   exp_result out  expected ALU result
//   exp_zero   out  expected ALU zero flag
module alu_vec_rom
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       ctrl,
    output logic [WIDTH-1:0] exp_result,
    output logic             exp_zero
);

    always_comb begin
        a          = '0;
        b          = '0;
        ctrl       = ALU_ADD;
        exp_result = '0;
        exp_zero   = 1'b0;
        case (idx)
            3'd0: begin
                a = WIDTH'(32'hABCDEFFA); b = WIDTH'(32'h12345678); ctrl = ALU_ADD;
                exp_result = WIDTH'(32'hBE024672); exp_zero = 1'b0;
            end
            3'd1: begin
                a = WIDTH'(32'hABCDEFFA); b = WIDTH'(32'h12345678); ctrl = ALU_SUB;
                exp_result = WIDTH'(32'h99999982); exp_zero = 1'b0;
            end
            3'd2: begin
                a = WIDTH'(32'hABCDEFFA); b = WIDTH'(32'h12345678); ctrl = ALU_AND;
                exp_result = WIDTH'(32'h02044678); exp_zero = 1'b0;
            end
            3'd3: begin
                a = WIDTH'(32'hABCDEFFA); b = WIDTH'(32'h12345678); ctrl = ALU_XOR;
                exp_result = WIDTH'(32'hB9F9B982); exp_zero = 1'b0;
            end
            3'd4: begin
                // Signed compare: ABCDEFFA is negative, so it is less.
                a = WIDTH'(32'hABCDEFFA); b = WIDTH'(32'h12345678); ctrl = ALU_SLT;
                exp_result = WIDTH'(32'h00000001); exp_zero = 1'b0;
            end
            3'd5: begin
                a = WIDTH'(32'h12345678); b = WIDTH'(32'hABCDEFFA); ctrl = ALU_SLT;
                exp_result = WIDTH'(32'h00000000); exp_zero = 1'b1;
            end
            3'd6: begin
                a = WIDTH'(32'h00000005); b = WIDTH'(32'h00000005); ctrl = ALU_SUB;
                exp_result = WIDTH'(32'h00000000); exp_zero = 1'b1;
            end
            default: begin
                // Carry out of bit 31 is discarded: result wraps to zero.
                a = WIDTH'(32'hFFFFFFFF); b = WIDTH'(32'h00000001); ctrl = ALU_ADD;
                exp_result = WIDTH'(32'h00000000); exp_zero = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// alu_bist: built-in self-test sequencer for the 32-bit Top_ALU.
// Drives each table vector onto the ALU, waits SETTLE extra cycles,
// then compares result/zero against the stored expectation.
//   clk, rst         clock, synchronous active-high reset
//   start            run request (honoured in IDLE or DONE)
//   busy, done, pass run status; pass valid while done=1
//   fail_count       saturating mismatch count
//   first_fail_idx   index of first mismatching vector
//   first_fail_vld   a mismatch has been recorded
//   alu_a/b/ctrl     registered stimulus to the ALU
//   alu_result/zero  ALU response
module alu_bist
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_VEC = 8,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_count,
    output logic [2:0]       first_fail_idx,
    output logic             first_fail_vld,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [3:0]         wait_reg;

    logic [WIDTH-1:0]   rom_a;
    logic [WIDTH-1:0]   rom_b;
    logic [2:0]         rom_ctrl;
    logic [WIDTH-1:0]   rom_exp_result;
    logic               rom_exp_zero;

    logic               mismatch;
    logic               last_vec;
    logic [3:0]         fail_next;

    alu_vec_rom #(
        .WIDTH (WIDTH)
    ) u_rom (
        .idx        (idx_reg),
        .a          (rom_a),
        .b          (rom_b),
        .ctrl       (rom_ctrl),
        .exp_result (rom_exp_result),
        .exp_zero   (rom_exp_zero)
    );

    // The ROM stays indexed by the vector under test through CHECK,
    // so its expectation lines up with the ALU response.
    always_comb begin
        mismatch  = (alu_result != rom_exp_result) || (alu_zero != rom_exp_zero);
        last_vec  = (idx_reg == IDX_W'(NUM_VEC - 1));
        fail_next = fail_count;
        if (mismatch && (fail_count != 4'hF)) begin
            fail_next = fail_count + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            wait_reg       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_ctrl       <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg      <= S_APPLY;
                        idx_reg        <= '0;
                        wait_reg       <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (wait_reg == 4'd0) begin
                        alu_a    <= rom_a;
                        alu_b    <= rom_b;
                        alu_ctrl <= rom_ctrl;
                    end
                    // With SETTLE=0 the load and the exit happen in the same cycle.
                    if (wait_reg == 4'(SETTLE)) begin
                        wait_reg  <= '0;
                        state_reg <= S_CHECK;
                    end else begin
                        wait_reg <= wait_reg + 4'd1;
                    end
                end
                S_CHECK: begin
                    fail_count <= fail_next;
                    if (mismatch && !first_fail_vld) begin
                        first_fail_idx <= idx_reg;
                        first_fail_vld <= 1'b1;
                    end
                    if (last_vec) begin
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (fail_next == 4'd0);
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= S_APPLY;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: directed self-checking bench for alu_bist. A behavioural
// Top_ALU sits on each BIST instance, with a fault mux to corrupt the
// response. A second instance is built with SETTLE=3.
module tb_alu_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start3 = 1'b0;
    int   fault_mode = 0;   // 0 none, 1 bit0 of result forced 0 on vector 4, 2 zero stuck-at-0

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // default instance
    logic        busy, done, pass, first_fail_vld, alu_zero;
    logic [3:0]  fail_count;
    logic [2:0]  first_fail_idx, alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;

    // SETTLE=3 instance
    logic        busy3, done3, pass3, first_fail_vld3, alu_zero3;
    logic [3:0]  fail_count3;
    logic [2:0]  first_fail_idx3, alu_ctrl3;
    logic [31:0] alu_a3, alu_b3, alu_result3;

    alu_bist dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx),
        .first_fail_vld(first_fail_vld), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
    );

    alu_bist #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_count(fail_count3), .first_fail_idx(first_fail_idx3),
        .first_fail_vld(first_fail_vld3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_ctrl(alu_ctrl3), .alu_result(alu_result3), .alu_zero(alu_zero3)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a ^ b;
            3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] raw_result;
    always_comb begin
        raw_result = alu_model(alu_a, alu_b, alu_ctrl);
        alu_result = raw_result;
        if (fault_mode == 1 && alu_ctrl == 3'b101 && alu_a == 32'hABCDEFFA)
            alu_result = raw_result & 32'hFFFFFFFE;
        alu_zero = (fault_mode == 2) ? 1'b0 : (alu_result == 32'd0);
        alu_result3 = alu_model(alu_a3, alu_b3, alu_ctrl3);
        alu_zero3   = (alu_result3 == 32'd0);
    end

    // operands/opcode the table should present, by vector index
    logic [31:0] exp_a [8] = '{32'hABCDEFFA, 32'hABCDEFFA, 32'hABCDEFFA, 32'hABCDEFFA,
                               32'hABCDEFFA, 32'h12345678, 32'h00000005, 32'hFFFFFFFF};
    logic [2:0]  exp_c [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b101, 3'b001, 3'b000};

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen; optional start
    // pulses are driven on the given edge offsets. n = -1 when the bound expires.
    task automatic wait_done(input int p1, input int p2, output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk) start = (k == p1 || k == p2);
            @(posedge clk);
            #1 start = 1'b0;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass, fail_count, first_fail_idx, first_fail_vld} !== 11'd0 ||
            alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b pass=%b fc=%0d a=%h b=%h ctrl=%b required all 0",
                     busy, done, pass, fail_count, alu_a, alu_b, alu_ctrl);
        end
        checks++;
        if ({busy3, done3, pass3, fail_count3, alu_a3} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs_s3 busy=%b done=%b a=%h required 0", busy3, done3, alu_a3);
        end
        @(negedge clk) rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic_pass;
        int n, vi;
        logic seq_bad;
        seq_bad = 1'b0;
        n = -1;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise busy=%b required 1", busy);
        end
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k <= 24) begin
                vi = (k - 1) / 3;
                if (alu_a !== exp_a[vi] || alu_ctrl !== exp_c[vi]) seq_bad = 1'b1;
            end
            if (done) begin
                n = k;
                break;
            end
        end
        checks++;
        if (seq_bad) begin
            errors++;
            $display("FAIL vector_sequence default build drove wrong operands/opcode");
        end
        checks++;
        if (n !== 24) begin
            errors++;
            $display("FAIL latency got %0d cycles required 24", n);
        end
        checks++;
        if (pass !== 1'b1 || busy !== 1'b0 || fail_count !== 4'd0 || first_fail_vld !== 1'b0) begin
            errors++;
            $display("FAIL good_alu_result pass=%b busy=%b fc=%0d vld=%b required 1 0 0 0",
                     pass, busy, fail_count, first_fail_vld);
        end
        checks++;
        if (alu_ctrl !== 3'b000 || alu_a !== 32'hFFFFFFFF || alu_b !== 32'h00000001) begin
            errors++;
            $display("FAIL final_vector ctrl=%b a=%h b=%h required 000 FFFFFFFF 00000001",
                     alu_ctrl, alu_a, alu_b);
        end
        $display("test_basic_pass latency=%0d pass=%b", n, pass);
    endtask

    task automatic test_result_fault;
        int n;
        fault_mode = 1;
        pulse_start();
        wait_done(0, 0, n);
        checks++;
        if (n !== 24 || fail_count !== 4'd1 || first_fail_idx !== 3'd4 ||
            first_fail_vld !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL result_fault n=%0d fc=%0d idx=%0d vld=%b pass=%b required 24 1 4 1 0",
                     n, fail_count, first_fail_idx, first_fail_vld, pass);
        end
        fault_mode = 0;
        $display("test_result_fault fc=%0d first=%0d", fail_count, first_fail_idx);
    endtask

    task automatic test_zero_stuck;
        int n;
        fault_mode = 2;
        pulse_start();
        wait_done(0, 0, n);
        checks++;
        if (n !== 24 || fail_count !== 4'd3 || first_fail_idx !== 3'd5 ||
            first_fail_vld !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL zero_stuck n=%0d fc=%0d idx=%0d vld=%b pass=%b required 24 3 5 1 0",
                     n, fail_count, first_fail_idx, first_fail_vld, pass);
        end
        // done is sticky and results are frozen while idle in DONE
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || fail_count !== 4'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky done=%b fc=%0d busy=%b required 1 3 0", done, fail_count, busy);
        end
        fault_mode = 0;
        $display("test_zero_stuck fc=%0d first=%0d", fail_count, first_fail_idx);
    endtask

    task automatic test_back_to_back;
        int n;
        // restart from DONE holding 3 failures: must clear
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || fail_count !== 4'd0 || first_fail_vld !== 1'b0 ||
            first_fail_idx !== 3'd0) begin
            errors++;
            $display("FAIL restart_clear done=%b busy=%b fc=%0d vld=%b idx=%0d required 0 1 0 0 0",
                     done, busy, fail_count, first_fail_vld, first_fail_idx);
        end
        wait_done(5, 10, n);
        checks++;
        if (n !== 24) begin
            errors++;
            $display("FAIL start_ignored_busy latency=%0d required 24", n);
        end
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL run_after_pulses pass=%b required 1", pass);
        end
        pulse_start();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_drop done=%b required 0", done);
        end
        wait_done(0, 0, n);
        checks++;
        if (n !== 24 || pass !== 1'b1 || fail_count !== 4'd0) begin
            errors++;
            $display("FAIL second_run n=%0d pass=%b fc=%0d required 24 1 0", n, pass, fail_count);
        end
        $display("test_back_to_back latency=%0d pass=%b", n, pass);
    endtask

    task automatic test_mid_reset;
        int n;
        fault_mode = 2;
        pulse_start();
        repeat (6) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass, fail_count, first_fail_idx, first_fail_vld} !== 11'd0 ||
            alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset busy=%b done=%b a=%h b=%h ctrl=%b required all 0",
                     busy, done, alu_a, alu_b, alu_ctrl);
        end
        @(negedge clk) rst = 1'b0;
        fault_mode = 0;
        // idle: nothing happens without start
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || alu_a !== 32'd0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b a=%h required 0 0", busy, alu_a);
        end
        pulse_start();
        wait_done(0, 0, n);
        checks++;
        if (n !== 24 || pass !== 1'b1) begin
            errors++;
            $display("FAIL run_after_reset n=%0d pass=%b required 24 1", n, pass);
        end
        $display("test_mid_reset latency=%0d pass=%b", n, pass);
    endtask

    task automatic test_settle3;
        int n, vi;
        n = -1;
        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k <= 40) begin
                vi = (k - 1) / 5;
                checks++;
                if (alu_a3 !== exp_a[vi] || alu_ctrl3 !== exp_c[vi]) begin
                    errors++;
                    $display("FAIL settle3_hold cycle=%0d a=%h ctrl=%b required %h %b",
                             k, alu_a3, alu_ctrl3, exp_a[vi], exp_c[vi]);
                end
            end
            if (done3) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n !== 40 || pass3 !== 1'b1 || fail_count3 !== 4'd0) begin
            errors++;
            $display("FAIL settle3_run n=%0d pass=%b fc=%0d required 40 1 0", n, pass3, fail_count3);
        end
        $display("test_settle3 latency=%0d pass=%b", n, pass3);
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_result_fault();
        test_zero_stuck();
        test_back_to_back();
        test_mid_reset();
        test_settle3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
